// File: rtl/spi_host_arbiter.sv
// rtl/spi_host_arbiter.sv - round-robin arbiter sharing one SPI host among NumReq requesters
// Grant, drain on host_busy_i, then an optional chip-select gap before the next grant.
module spi_host_arbiter #(
  parameter int NumReq        = 4,
  parameter int GapCycles     = 2,
  parameter int TimeoutCycles = 65535
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_i,
  input  logic [NumReq-1:0]         release_i,
  input  logic                      host_busy_i,
  output logic [NumReq-1:0]         grant_o,
  output logic [$clog2(NumReq)-1:0] grant_idx_o,
  output logic                      granted_o,
  output logic                      cs_gap_o,
  output logic                      timeout_o,
  output logic [$clog2(NumReq)-1:0] timeout_id_o
);

  localparam int IdxW = $clog2(NumReq);
  localparam logic [15:0] HoldLast = 16'(TimeoutCycles - 1);
  localparam logic [3:0]  GapLast  = 4'(GapCycles - 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, GAP} state_e;

  state_e            state_q, state_d;
  logic [NumReq-1:0] grant_q, grant_d;
  logic              granted_q, granted_d;
  logic [IdxW-1:0]   last_owner_q, last_owner_d;
  logic [IdxW-1:0]   timeout_id_q, timeout_id_d;
  logic [15:0]       hold_q, hold_d;
  logic [3:0]        gap_q, gap_d;
  logic              cs_gap_q, cs_gap_d;
  logic              timeout_q, timeout_d;

  logic              pick_vld;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW-1:0]   cand;

  // Walk from farthest to nearest so the first hit after last_owner wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_owner_q;
    cand     = last_owner_q;
    for (int k = NumReq; k >= 1; k--) begin
      cand = IdxW'((int'(last_owner_q) + k) % NumReq);
      if (req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    timeout_id_d = timeout_id_q;
    hold_d       = hold_q;
    gap_d        = gap_q;
    cs_gap_d     = 1'b0;
    timeout_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d           = GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          last_owner_d      = pick_idx;
          hold_d            = '0;
        end
      end
      GRANT: begin
        if (release_i[last_owner_q] || !req_i[last_owner_q]) begin
          state_d = DRAIN;
          grant_d = '0;
        end else if (hold_q == HoldLast) begin
          state_d      = DRAIN;
          grant_d      = '0;
          timeout_d    = 1'b1;
          timeout_id_d = last_owner_q;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      DRAIN: begin
        if (!host_busy_i) begin
          if (GapCycles == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = GAP;
            cs_gap_d = 1'b1;
            gap_d    = '0;
          end
        end
      end
      GAP: begin
        if (gap_q == GapLast) begin
          state_d = IDLE;
        end else begin
          gap_d    = gap_q + 4'd1;
          cs_gap_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    granted_d = |grant_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      granted_q    <= 1'b0;
      last_owner_q <= IdxW'(NumReq - 1);
      timeout_id_q <= '0;
      hold_q       <= '0;
      gap_q        <= '0;
      cs_gap_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      granted_q    <= granted_d;
      last_owner_q <= last_owner_d;
      timeout_id_q <= timeout_id_d;
      hold_q       <= hold_d;
      gap_q        <= gap_d;
      cs_gap_q     <= cs_gap_d;
      timeout_q    <= timeout_d;
    end
  end

  assign grant_o      = grant_q;
  assign granted_o    = granted_q;
  assign grant_idx_o  = last_owner_q;
  assign cs_gap_o     = cs_gap_q;
  assign timeout_o    = timeout_q;
  assign timeout_id_o = timeout_id_q;

endmodule

// File: tb/tb_spi_host_arbiter.sv
// tb/tb_spi_host_arbiter.sv - scoreboard bench for spi_host_arbiter
// Stimulus pushes expected grants/timeouts/hold lengths; a negedge monitor pops and compares.
module tb_spi_host_arbiter;

  localparam int NR  = 4;
  localparam int GAP = 2;
  localparam int TO  = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [NR-1:0] req_i;
  logic [NR-1:0] release_i;
  logic          host_busy_i;
  logic [NR-1:0] grant_o;
  logic [1:0]    grant_idx_o;
  logic          granted_o;
  logic          cs_gap_o;
  logic          timeout_o;
  logic [1:0]    timeout_id_o;

  int total = 0;
  int bad   = 0;
  int last_m = NR - 1;
  bit skip_len = 1'b0;
  int exp_grant[$];
  int exp_to[$];
  int exp_len[$];

  spi_host_arbiter #(.NumReq(NR), .GapCycles(GAP), .TimeoutCycles(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .release_i    (release_i),
    .host_busy_i  (host_busy_i),
    .grant_o      (grant_o),
    .grant_idx_o  (grant_idx_o),
    .granted_o    (granted_o),
    .cs_gap_o     (cs_gap_o),
    .timeout_o    (timeout_o),
    .timeout_id_o (timeout_id_o)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // First requester at or after (last+1) mod NR, wrapping.
  function automatic int rr(input logic [3:0] pat, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (((int'(pat) >> ((last + k) % NR)) & 1) != 0) return (last + k) % NR;
    end
    return 0;
  endfunction

  // c: negedges after first grant cycle before release; b: host_busy cycles in drain.
  task automatic txn(input logic [3:0] pat, input int c, input int b, input bit use_rel,
                     input bit do_rst, input bit lat1);
    int w;
    int n;
    w = rr(pat, last_m);
    last_m = w;
    exp_grant.push_back(w);
    req_i = pat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!granted_o && n < 60);
    if (!granted_o) begin
      check(1'b0, "grant_wait", n, 60);
      req_i = '0;
      return;
    end
    if (lat1) check(n == 1, "grant_latency", n, 1);
    if (do_rst) begin
      skip_len = 1'b1;
      rst_i = 1'b1;
      req_i = '0;
      @(negedge clk);
      rst_i = 1'b0;
      check(grant_o == 0, "rst_grant", int'(grant_o), 0);
      check(granted_o == 0, "rst_granted", int'(granted_o), 0);
      check(cs_gap_o == 0, "rst_cs_gap", int'(cs_gap_o), 0);
      check(timeout_o == 0, "rst_timeout", int'(timeout_o), 0);
      check(timeout_id_o == 0, "rst_timeout_id", int'(timeout_id_o), 0);
      check(grant_idx_o == 2'(NR - 1), "rst_grant_idx", int'(grant_idx_o), NR - 1);
      last_m = NR - 1;
      return;
    end
    if (c >= TO) exp_to.push_back(w);
    exp_len.push_back((c >= TO - 1) ? TO : c + 1);
    repeat (c) @(negedge clk);
    if (use_rel) release_i[w] = 1'b1;
    else req_i = '0;
    host_busy_i = (b > 0);
    @(negedge clk);
    release_i = '0;
    req_i = '0;
    check(grant_o == 0, "grant_drop", int'(grant_o), 0);
    for (int j = 1; j <= b; j++) begin
      check(grant_o == 0 && cs_gap_o == 0, "drain_busy", int'({grant_o, cs_gap_o}), 0);
      if (j < b) begin
        req_i = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
    end
    req_i = '0;
    host_busy_i = 1'b0;
  endtask

  initial begin : monitor
    bit prev_g;
    logic [NR-1:0] prev_gv;
    int glen;
    int gaplen;
    int e;
    prev_g = 1'b0;
    prev_gv = '0;
    glen = 0;
    gaplen = 0;
    wait (rst_i == 1'b0);
    forever begin
      @(negedge clk);
      if (granted_o && !prev_g) begin
        if (exp_grant.size() == 0) begin
          check(1'b0, "grant_unexpected", int'(grant_o), 0);
        end else begin
          e = exp_grant.pop_front();
          check(grant_o == (4'b0001 << e), "grant_vec", int'(grant_o), 1 << e);
          check(int'(grant_idx_o) == e, "grant_idx", int'(grant_idx_o), e);
        end
        glen = 1;
      end else if (granted_o) begin
        check(grant_o == prev_gv, "grant_hold", int'(grant_o), int'(prev_gv));
        glen++;
      end else if (prev_g) begin
        if (skip_len) begin
          skip_len = 1'b0;
        end else if (exp_len.size() == 0) begin
          check(1'b0, "len_unexpected", glen, 0);
        end else begin
          e = exp_len.pop_front();
          check(glen == e, "grant_len", glen, e);
        end
        glen = 0;
      end
      if (timeout_o) begin
        if (exp_to.size() == 0) begin
          check(1'b0, "timeout_unexpected", int'(timeout_id_o), -1);
        end else begin
          e = exp_to.pop_front();
          check(int'(timeout_id_o) == e, "timeout_id", int'(timeout_id_o), e);
        end
      end
      if (cs_gap_o) begin
        gaplen++;
        check(!granted_o, "gap_vs_grant", int'(granted_o), 0);
      end else if (gaplen > 0) begin
        check(gaplen == GAP, "gap_len", gaplen, GAP);
        gaplen = 0;
      end
      prev_g = granted_o;
      prev_gv = grant_o;
    end
  end

  initial begin : stim
    rst_i = 1'b1;
    req_i = '0;
    release_i = '0;
    host_busy_i = 1'b0;
    repeat (3) @(negedge clk);
    check(grant_o == 0, "reset_grant", int'(grant_o), 0);
    check(granted_o == 0, "reset_granted", int'(granted_o), 0);
    check(cs_gap_o == 0, "reset_cs_gap", int'(cs_gap_o), 0);
    check(timeout_o == 0, "reset_timeout", int'(timeout_o), 0);
    check(grant_idx_o == 2'(NR - 1), "reset_grant_idx", int'(grant_idx_o), NR - 1);
    rst_i = 1'b0;

    txn(4'b0110, 3, 0, 1'b1, 1'b0, 1'b1);
    txn(4'b1000, 2, 0, 1'b1, 1'b1, 1'b0);
    txn(4'b1111, 2, 0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) txn(4'b1111, 2, 0, 1'b1, 1'b0, 1'b0);
    txn(4'b0100, 9, 0, 1'b1, 1'b0, 1'b0);
    txn(4'b0100, TO - 1, 0, 1'b1, 1'b0, 1'b0);
    txn(4'b0100, TO - 1, 0, 1'b0, 1'b0, 1'b0);
    txn(4'b0011, 1, 5, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] pat;
      int c;
      int b;
      pat = 4'($urandom_range(1, 15));
      c = $urandom_range(0, 9);
      b = (c < TO) ? $urandom_range(0, 5) : 0;
      txn(pat, c, b, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    repeat (20) @(negedge clk);
    check(exp_grant.size() == 0, "grants_left", exp_grant.size(), 0);
    check(exp_to.size() == 0, "timeouts_left", exp_to.size(), 0);
    check(exp_len.size() == 0, "lens_left", exp_len.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
